// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - digital-clock seconds/minutes chain with hour carry and button set mode
// Optional feature macro: CLOCK_TIME_CTRL_BLINK_EN (blink toggle register for the edited field)
module clock_time_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [7:0] hour_q,
    output logic       hour_in,
    output logic       hour_load,
    output logic [7:0] hour_data,
    output logic [7:0] min_q,
    output logic [7:0] sec_q,
    output logic [1:0] set_mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic [7:0] sec_d;
    logic [7:0] min_d;
    logic       hour_in_d;
    logic       hour_load_d;
    logic [7:0] hour_data_d;

    // BCD 00..59 increment with wrap; a corrupt low nibble is treated as 9
    function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
        if (v[3:0] >= 4'd9) begin
            if (v[7:4] >= 4'd5)
                return 8'h00;
            else
                return {v[7:4] + 4'd1, 4'h0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // BCD 00..23 increment; anything that is not a valid hour restarts at 00
    function automatic logic [7:0] hour_inc(input logic [7:0] h);
        if (h >= 8'h23 || h[3:0] > 4'd9)
            return 8'h00;
        else if (h[3:0] == 4'd9)
            return {h[7:4] + 4'd1, 4'h0};
        else
            return {h[7:4], h[3:0] + 4'd1};
    endfunction

    // State register; the encoding is exported directly as set_mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= RUN;
        else
            state <= state_nx;
    end

    // Next state: each mode press advances RUN -> SET_HR -> SET_MIN -> RUN
    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (mode_btn) state_nx = SET_HR;
            SET_HR:  if (mode_btn) state_nx = SET_MIN;
            SET_MIN: if (mode_btn) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // Next values for the registered datapath outputs, decoded from the current state
    always_comb begin
        sec_d       = sec_q;
        min_d       = min_q;
        hour_in_d   = 1'b0;
        hour_load_d = 1'b0;
        hour_data_d = hour_data;
        case (state)
            RUN: begin
                // A coincident mode press does not block the tick or its carry
                if (tick) begin
                    sec_d = bcd_inc59(sec_q);
                    if (sec_q == 8'h59) begin
                        min_d = bcd_inc59(min_q);
                        if (min_q == 8'h59)
                            hour_in_d = 1'b1;
                    end
                end
            end
            SET_HR: begin
                // hour_load high means hour_q still shows the pre-load value, so drop this press
                if (inc_btn && !mode_btn && !hour_load) begin
                    hour_load_d = 1'b1;
                    hour_data_d = hour_inc(hour_q);
                end
            end
            SET_MIN: begin
                if (mode_btn)
                    sec_d = 8'h00;
                else if (inc_btn)
                    min_d = bcd_inc59(min_q);
            end
            default: ;
        endcase
    end

    // Datapath output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_q     <= 8'h00;
            min_q     <= 8'h00;
            hour_in   <= 1'b0;
            hour_load <= 1'b0;
            hour_data <= 8'h00;
        end else begin
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_in   <= hour_in_d;
            hour_load <= hour_load_d;
            hour_data <= hour_data_d;
        end
    end

    assign set_mode = state;

`ifdef CLOCK_TIME_CTRL_BLINK_EN
    // Blink phase toggles per tick while editing; restarts dark on any mode change
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            blink <= 1'b0;
        else if (state == RUN || state_nx != state)
            blink <= 1'b0;
        else if (tick)
            blink <= ~blink;
    end
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - directed table-driven bench for clock_time_ctrl
module tb_clock_time_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       mode_btn;
    logic       inc_btn;
    logic [7:0] hour_q;
    logic       hour_in;
    logic       hour_load;
    logic [7:0] hour_data;
    logic [7:0] min_q;
    logic [7:0] sec_q;
    logic [1:0] set_mode;
    logic       blink;

    int compared   = 0;
    int mismatched = 0;

    clock_time_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .hour_q    (hour_q),
        .hour_in   (hour_in),
        .hour_load (hour_load),
        .hour_data (hour_data),
        .min_q     (min_q),
        .sec_q     (sec_q),
        .set_mode  (set_mode),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       t;
        logic       m;
        logic       i;
        logic [7:0] hq;
        logic [7:0] e_sec;
        logic [7:0] e_min;
        logic [1:0] e_mode;
        logic       e_hin;
        logic       e_hld;
        logic [7:0] e_hdata;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(logic t, logic m, logic i, logic [7:0] hq,
                                logic [7:0] es, logic [7:0] em, logic [1:0] emd,
                                logic ehin, logic ehld, logic [7:0] ehd);
        vec_t v;
        v.t = t; v.m = m; v.i = i; v.hq = hq;
        v.e_sec = es; v.e_min = em; v.e_mode = emd;
        v.e_hin = ehin; v.e_hld = ehld; v.e_hdata = ehd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] es, input logic [7:0] em,
                           input logic [1:0] emd, input logic ehin, input logic ehld,
                           input logic [7:0] ehd);
        chk({tag, ".sec_q"},     {24'h0, sec_q},     {24'h0, es});
        chk({tag, ".min_q"},     {24'h0, min_q},     {24'h0, em});
        chk({tag, ".set_mode"},  {30'h0, set_mode},  {30'h0, emd});
        chk({tag, ".hour_in"},   {31'h0, hour_in},   {31'h0, ehin});
        chk({tag, ".hour_load"}, {31'h0, hour_load}, {31'h0, ehld});
        chk({tag, ".hour_data"}, {24'h0, hour_data}, {24'h0, ehd});
        chk({tag, ".blink"},     {31'h0, blink},     32'h0);
    endtask

    // One clock: inputs driven at the falling edge, pulses removed just after the rising edge
    task automatic step(input logic t, input logic m, input logic i, input logic [7:0] hq);
        @(negedge clk);
        tick = t; mode_btn = m; inc_btn = i; hour_q = hq;
        @(posedge clk);
        #1;
        tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0; hour_q = 8'h00;

        //               t     m     i     hq     sec    min   mode   hin   hld   hdata
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00);
        vecs[2]  = mk(1'b1, 1'b0, 1'b1, 8'h00, 8'h02, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00);
        vecs[3]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 8'h03, 8'h00, 2'b01, 1'b0, 1'b0, 8'h00);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 8'h00, 2'b01, 1'b0, 1'b0, 8'h00);
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, 8'h23, 8'h03, 8'h00, 2'b01, 1'b0, 1'b1, 8'h00);
        vecs[6]  = mk(1'b0, 1'b0, 1'b1, 8'h09, 8'h03, 8'h00, 2'b01, 1'b0, 1'b0, 8'h00);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 8'h09, 8'h03, 8'h00, 2'b01, 1'b0, 1'b1, 8'h10);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 8'h10, 8'h03, 8'h00, 2'b01, 1'b0, 1'b0, 8'h10);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 8'h2A, 8'h03, 8'h00, 2'b01, 1'b0, 1'b1, 8'h00);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 8'h00, 2'b01, 1'b0, 1'b0, 8'h00);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 8'h19, 8'h03, 8'h00, 2'b01, 1'b0, 1'b1, 8'h20);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 8'h20, 8'h03, 8'h00, 2'b01, 1'b0, 1'b0, 8'h20);
        vecs[13] = mk(1'b0, 1'b0, 1'b1, 8'h1A, 8'h03, 8'h00, 2'b01, 1'b0, 1'b1, 8'h00);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 8'h00, 2'b01, 1'b0, 1'b0, 8'h00);
        vecs[15] = mk(1'b0, 1'b1, 1'b1, 8'h05, 8'h03, 8'h00, 2'b10, 1'b0, 1'b0, 8'h00);
        vecs[16] = mk(1'b1, 1'b0, 1'b0, 8'h05, 8'h03, 8'h00, 2'b10, 1'b0, 1'b0, 8'h00);
        vecs[17] = mk(1'b0, 1'b0, 1'b1, 8'h05, 8'h03, 8'h01, 2'b10, 1'b0, 1'b0, 8'h00);
        vecs[18] = mk(1'b1, 1'b0, 1'b1, 8'h05, 8'h03, 8'h02, 2'b10, 1'b0, 1'b0, 8'h00);
        vecs[19] = mk(1'b0, 1'b1, 1'b0, 8'h05, 8'h00, 8'h02, 2'b00, 1'b0, 1'b0, 8'h00);
        vecs[20] = mk(1'b1, 1'b0, 1'b0, 8'h05, 8'h01, 8'h02, 2'b00, 1'b0, 1'b0, 8'h00);

        // Reset state while reset is held
        #12;
        chk_all("reset", 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Table of single-cycle vectors
        for (int k = 0; k < 21; k++) begin
            step(vecs[k].t, vecs[k].m, vecs[k].i, vecs[k].hq);
            chk_all($sformatf("vec%0d", k), vecs[k].e_sec, vecs[k].e_min, vecs[k].e_mode,
                    vecs[k].e_hin, vecs[k].e_hld, vecs[k].e_hdata);
        end

        // Rollover: 00:58:59 -> 59:00 without carry, then 59:58 -> 59:59 -> 00:00 with one carry
        do_reset();
        for (int k = 0; k < 3539; k++) step(1'b1, 1'b0, 1'b0, 8'h00);
        chk_all("t5859", 8'h59, 8'h58, 2'b00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk_all("t5900", 8'h00, 8'h59, 2'b00, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 58; k++) step(1'b1, 1'b0, 1'b0, 8'h00);
        chk_all("t5958", 8'h58, 8'h59, 2'b00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk_all("t5959", 8'h59, 8'h59, 2'b00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk_all("carry", 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk_all("carry_end", 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00);

        // Tick with mode at 59:59 in RUN: carry applied and state changes on the same edge
        for (int k = 0; k < 3599; k++) step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        chk_all("tick_mode", 8'h00, 8'h00, 2'b01, 1'b1, 1'b0, 8'h00);

        // SET_MIN wrap 59 -> 00 with no carry, then back to RUN clears seconds
        do_reset();
        for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 59; k++) step(1'b0, 1'b0, 1'b1, 8'h00);
        chk_all("smin59", 8'h07, 8'h59, 2'b10, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk_all("smin_wrap", 8'h07, 8'h00, 2'b10, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk_all("smin_exit", 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset mid-SET_MIN at minute 37
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 37; k++) step(1'b0, 1'b0, 1'b1, 8'h00);
        chk_all("pre_arst", 8'h05, 8'h37, 2'b10, 1'b0, 1'b0, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        chk_all("arst", 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
